// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the buffered UART bridge.
// The TX FSM state enum, the ARM busy-wait timeout and the default sizes live here.
package uart_bridge_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_TX_DEPTH = 16;
    localparam int DEF_RX_DEPTH = 16;

    // Cycles the FSM waits in ARM for the PHY to raise busy before moving on.
    localparam int ARM_TIMEOUT  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head and an exact occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
    import uart_bridge_pkg::*;
#(
    parameter int W     = DEF_DATA_W,
    parameter int DEPTH = DEF_TX_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic          push_ok;
    logic          pop_ok;
    logic          many;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign many       = (count[AW:1] != '0);
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr_nxt;

            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Head register: next entry, or the incoming byte when it becomes the head.
            if (empty && push_ok)
                dout <= din;
            else if (pop_ok && many)
                dout <= mem[rd_ptr_nxt];
            else if (pop_ok && push_ok)
                dout <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered bridge between the core UART register port and the UART PHY, with TX/RX FIFOs.
// Optional UART_LOOPBACK_EN adds a loopback input that routes popped TX bytes into the RX FIFO.
//
// state | meaning
// IDLE  | waiting for a queued byte and an idle PHY; pops and pulses phy_tx_start
// ARM   | start issued; waiting up to ARM_TIMEOUT cycles for phy_tx_busy=1
// SEND  | PHY transmitting; waiting for phy_tx_busy=0
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TX_DEPTH = DEF_TX_DEPTH,
    parameter int RX_DEPTH = DEF_RX_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           core_tx_data,
    input  logic                        core_tx_en,
    output logic                        core_tx_status,
    output logic [DATA_W-1:0]           core_rx_data,
    output logic                        core_rx_eff,
    input  logic                        core_rx_read,
    output logic [DATA_W-1:0]           phy_tx_data,
    output logic                        phy_tx_start,
    input  logic                        phy_tx_busy,
    input  logic [DATA_W-1:0]           phy_rx_data,
    input  logic                        phy_rx_valid,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overrun,
    input  logic                        ovr_clr
`ifdef UART_LOOPBACK_EN
    ,
    input  logic                        loopback
`endif
);

    localparam logic [1:0] ARM_LOAD = 2'(ARM_TIMEOUT - 1);

    tx_state_t          state_q;
    tx_state_t          state_d;
    logic [1:0]         arm_tmr_q;
    logic [1:0]         arm_tmr_d;
    logic               start_d;
    logic               tx_pop;
    logic               loop_push;
    logic               loop_en;
    logic [DATA_W-1:0]  tx_head;
    logic               tx_full;
    logic               tx_empty;

    logic               rx_push;
    logic [DATA_W-1:0]  rx_din;
    logic               rx_full;
    logic               rx_empty;
    logic               ovr_set;

`ifdef UART_LOOPBACK_EN
    assign loop_en = loopback;
`else
    assign loop_en = 1'b0;
`endif

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (core_tx_en),
        .din   (core_tx_data),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign core_tx_status = !tx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            arm_tmr_q    <= '0;
            phy_tx_start <= 1'b0;
            phy_tx_data  <= '0;
        end else begin
            state_q      <= state_d;
            arm_tmr_q    <= arm_tmr_d;
            phy_tx_start <= start_d;
            if (tx_pop) phy_tx_data <= tx_head;
        end
    end

    always_comb begin
        state_d   = state_q;
        arm_tmr_d = arm_tmr_q;
        start_d   = 1'b0;
        tx_pop    = 1'b0;
        loop_push = 1'b0;
        case (state_q)
            IDLE: begin
                // Looped bytes bypass the PHY, so its busy flag does not gate them.
                if (!tx_empty && (loop_en || !phy_tx_busy)) begin
                    tx_pop = 1'b1;
                    if (loop_en) begin
                        loop_push = 1'b1;
                    end else begin
                        start_d   = 1'b1;
                        arm_tmr_d = ARM_LOAD;
                        state_d   = ARM;
                    end
                end
            end
            ARM: begin
                if (phy_tx_busy || (arm_tmr_q == '0))
                    state_d = SEND;
                else
                    arm_tmr_d = arm_tmr_q - 1'b1;
            end
            SEND: begin
                if (!phy_tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A looped byte owns the RX write port; a PHY byte arriving with it is lost.
    assign rx_push = loop_push || phy_rx_valid;
    assign rx_din  = loop_push ? tx_head : phy_rx_data;
    assign ovr_set = (loop_push && phy_rx_valid) ||
                     (rx_push && rx_full && !core_rx_read);

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (rx_din),
        .pop   (core_rx_read),
        .dout  (core_rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign core_rx_eff = !rx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rx_overrun <= 1'b0;
        else if (ovr_set)
            rx_overrun <= 1'b1;
        else if (ovr_clr)
            rx_overrun <= 1'b0;
    end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
Parametrised buffered UART bridge between the pipeline core's UART register port (TXD/TX_EN/TX_STATUS, RXD/RX_EFF/RX_READ) and the UART sender/receiver PHY. It decouples the core from serial timing with independent TX and RX FIFOs. A TX state machine paces bytes into the PHY using its busy handshake. It adds depth, width generality, occupancy counts and overrun reporting, which the unbuffered single-byte path lacks.

Parameters:
DATA_W, 8, data width of each UART character.
TX_DEPTH, 16, TX FIFO entries; power of 2, at least 2.
RX_DEPTH, 16, RX FIFO entries; power of 2, at least 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-low reset.
core_tx_data  in  DATA_W  byte written by the core.
core_tx_en  in  1  one-cycle push strobe into the TX FIFO.
core_tx_status  out  1  1 = TX FIFO not full; the core may push.
core_rx_data  out  DATA_W  head of the RX FIFO.
core_rx_eff  out  1  1 = RX FIFO not empty.
core_rx_read  in  1  one-cycle pop strobe from the RX FIFO.
phy_tx_data  out  DATA_W  byte presented to the PHY sender.
phy_tx_start  out  1  one-cycle start pulse to the PHY sender.
phy_tx_busy  in  1  PHY sender busy.
phy_rx_data  in  DATA_W  byte from the PHY receiver.
phy_rx_valid  in  1  one-cycle pulse; phy_rx_data is valid.
tx_count  out  clog2(TX_DEPTH)+1  TX FIFO occupancy.
rx_count  out  clog2(RX_DEPTH)+1  RX FIFO occupancy.
rx_overrun  out  1  sticky flag: an RX byte was dropped.
ovr_clr  in  1  one-cycle pulse that clears rx_overrun.

Behaviour:
- Reset (reset=0, asynchronous):
  - All FIFO pointers and counts go to 0.
  - tx_count=0, rx_count=0, core_tx_status=1, core_rx_eff=0, core_rx_data=0.
  - phy_tx_data=0, phy_tx_start=0, rx_overrun=0, TX FSM=IDLE.
  - Reset mid-transfer abandons FIFO contents. A byte already in the PHY is not tracked.
- TX FIFO:
  - Push on core_tx_en when not full.
  - Push while full: byte dropped, no state change. The core must honour core_tx_status.
  - Push and FSM pop in the same cycle: both take effect and tx_count is unchanged. This includes the full case, because the pop frees a slot in that cycle.
- TX FSM, states IDLE, ARM, SEND:
  - IDLE: if TX FIFO not empty and phy_tx_busy=0, pop the head into the phy_tx_data register and assert phy_tx_start for exactly one cycle. Next state is ARM.
  - ARM: wait for phy_tx_busy=1, then go to SEND. If busy is not seen within 2 cycles, go to SEND anyway; this covers a PHY that starts late or never reports busy.
  - SEND: wait for phy_tx_busy=0, then go to IDLE.
  - At most one byte is in flight at a time. Minimum spacing between start pulses is 3 cycles.
  - phy_tx_data holds its value until the next pop.
- RX FIFO:
  - Push on phy_rx_valid.
  - If full and core_rx_read is not asserted in the same cycle: byte dropped and rx_overrun set.
  - If full and core_rx_read is asserted in the same cycle: byte accepted.
  - First-word fall-through: core_rx_data always shows the head entry. It updates on the cycle after a pop.
  - Pop while empty: ignored; core_rx_data holds its value.
- rx_overrun:
  - Set has priority over ovr_clr in the same cycle.
  - Clears only on ovr_clr or reset.
- Counts:
  - Counts are registered and exact; they never wrap. A value of DEPTH means full.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Latency:
  - Core push to phy_tx_start: 2 cycles when the FSM is IDLE and the PHY is idle.
  - phy_rx_valid to core_rx_eff=1: 1 cycle.

Optional Feature:
UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit).
  - While loopback=1, each byte popped by the TX FSM is pushed into the RX FIFO in the same cycle.
  - phy_tx_start stays 0 and the FSM returns directly to IDLE.
  - Overrun rules apply to looped bytes as well.
  - If phy_rx_valid coincides with a looped byte, the PHY byte is dropped and rx_overrun is set.
- Undefined: the loopback port is absent and behaviour is exactly as above.

Decomposition:
- Package uart_bridge_pkg holds:
  - the TX FSM state enum (IDLE, ARM, SEND);
  - ARM_TIMEOUT=2;
  - default DATA_W/DEPTH constants.
- Sub-module sync_fifo (parameters W, DEPTH): push, pop, full, empty, count, FWFT head. Instantiated twice, for TX and RX.

Test Plan:
- Reset low mid-SEND with 5 bytes queued -> within the same cycle: tx_count=0, phy_tx_start=0, core_tx_status=1; after reset releases, FSM is IDLE.
- Push 0x41,0x42,0x43 back-to-back; PHY model holds busy for 10 cycles per byte -> three start pulses, phy_tx_data sequence 41,42,43, spacing ≥12 cycles, tx_count ends at 0.
- Push 17 bytes at DEPTH=16 with PHY stalled busy -> core_tx_status=0 after the 16th push, 17th byte dropped, 16 bytes later transmitted in order.
- Inject 16 RX bytes 0x00..0x0F, then 0xFF with no read -> rx_count=16, rx_overrun=1, reads return 00..0F and 0xFF never appears. ovr_clr clears the flag.
- RX FIFO full, phy_rx_valid=0x55 and core_rx_read in the same cycle -> no overrun, rx_count stays 16, 0x55 is the last byte read.
- With UART_LOOPBACK_EN and loopback=1, push 0xA5 -> no phy_tx_start; core_rx_eff=1 with core_rx_data=0xA5 within 3 cycles.
